// File: rtl/mesi_isc_broad_snoop_cntl.sv
// Broadcast FIFO consumer: pops one request, snoops every non-originating CPU,
// then grants the originator. Optional ack watchdog: MESI_ISC_BROAD_TIMEOUT_EN.
module mesi_isc_broad_snoop_cntl #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7,
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        broad_fifo_empty_i,
  input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
  input  logic [1:0]                  broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
  output logic                        broad_fifo_rd_o,
  output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
  output logic [4*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
  input  logic [3:0]                  cbus_ack_array_i,
  output logic [BROAD_ID_WIDTH-1:0]   broad_id_o,
  output logic                        busy_o,
  output logic                        timeout_err_o
);
  localparam int NUM_CPU = 4;
  localparam logic [BROAD_TYPE_WIDTH-1:0] BT_NOP = BROAD_TYPE_WIDTH'(0);
  localparam logic [BROAD_TYPE_WIDTH-1:0] BT_WR  = BROAD_TYPE_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] C_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_ENABLE} state_t;

  state_t                                  r_state, w_state_n;
  logic [NUM_CPU-1:0][CBUS_CMD_WIDTH-1:0]  r_cmd, w_cmd_n;
  logic [NUM_CPU-1:0]                      r_done, w_done_n, w_ack_acc;
  logic [1:0]                              r_cpu;
  logic                                    r_wr;
  logic [ADDR_WIDTH-1:0]                   r_addr;
  logic [BROAD_ID_WIDTH-1:0]               r_id;
  logic                                    r_busy;
  logic                                    w_pop, w_start;
  logic [CBUS_CMD_WIDTH-1:0]               w_snoop_cmd;

  // An ack only counts while that CPU is being driven a real command.
  for (genvar g = 0; g < NUM_CPU; g++) begin : g_ack
    assign w_ack_acc[g] = cbus_ack_array_i[g] && (r_cmd[g] != C_NOP);
  end

  // Pop is decoded from the state register so a NOP entry costs one cycle.
  assign w_pop       = (r_state == S_IDLE) && !broad_fifo_empty_i && !rst;
  assign w_start     = w_pop && (broad_type_i != BT_NOP);
  assign w_snoop_cmd = (broad_type_i == BT_WR) ? C_WR_SNOOP : C_RD_SNOOP;

  always_comb begin
    w_state_n = r_state;
    w_cmd_n   = r_cmd;
    w_done_n  = r_done;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_n = S_SNOOP;
          // Originator is pre-marked done so it never sees a snoop.
          w_done_n                 = '0;
          w_done_n[broad_cpu_id_i] = 1'b1;
          for (int i = 0; i < NUM_CPU; i++)
            w_cmd_n[i] = (broad_cpu_id_i == 2'(i)) ? C_NOP : w_snoop_cmd;
        end
      end
      S_SNOOP: begin
        w_done_n = r_done | w_ack_acc;
        if (&w_done_n) begin
          w_state_n = S_ENABLE;
          for (int i = 0; i < NUM_CPU; i++)
            w_cmd_n[i] = (r_cpu == 2'(i)) ? (r_wr ? C_EN_WR : C_EN_RD) : C_NOP;
        end else begin
          for (int i = 0; i < NUM_CPU; i++)
            if (w_done_n[i]) w_cmd_n[i] = C_NOP;
        end
      end
      S_ENABLE: begin
        if (w_ack_acc[r_cpu]) begin
          w_state_n = S_IDLE;
          w_cmd_n   = '0;
          w_done_n  = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cmd_n   = '0;
        w_done_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_done  <= '0;
      r_cpu   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_id    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cmd   <= w_cmd_n;
      r_done  <= w_done_n;
      r_busy  <= (w_state_n != S_IDLE);
      if (w_start) begin
        r_cpu  <= broad_cpu_id_i;
        r_wr   <= (broad_type_i == BT_WR);
        r_addr <= broad_addr_i;
        r_id   <= broad_id_i;
      end
    end
  end

`ifdef MESI_ISC_BROAD_TIMEOUT_EN
  logic [15:0] r_cnt, w_cnt_n;
  logic        r_tmo;

  // Counts cycles in service since the last accepted ack; saturates.
  always_comb begin
    w_cnt_n = r_cnt;
    if (w_start || (|w_ack_acc) || (r_state == S_IDLE)) w_cnt_n = '0;
    else if (r_cnt != '1)                                w_cnt_n = r_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_n;
      if ((r_state != S_IDLE) && (w_cnt_n == 16'(TIMEOUT_CYCLES))) r_tmo <= 1'b1;
    end
  end

  assign timeout_err_o = r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo  = |32'(TIMEOUT_CYCLES);
  assign timeout_err_o = 1'b0;
`endif

  assign broad_fifo_rd_o  = w_pop;
  assign cbus_addr_o      = r_addr;
  assign cbus_cmd_array_o = r_cmd;
  assign broad_id_o       = r_id;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_mesi_isc_broad_snoop_cntl.sv
// Bench for mesi_isc_broad_snoop_cntl: directed scenarios plus random traffic
// against a pending-snoop-set model. Timeout scenario needs MESI_ISC_BROAD_TIMEOUT_EN.
module tb_mesi_isc_broad_snoop_cntl;
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        broad_fifo_empty_i;
  logic [31:0] broad_addr_i;
  logic [1:0]  broad_type_i;
  logic [1:0]  broad_cpu_id_i;
  logic [6:0]  broad_id_i;
  logic        broad_fifo_rd_o;
  logic [31:0] cbus_addr_o;
  logic [11:0] cbus_cmd_array_o;
  logic [3:0]  cbus_ack_array_i;
  logic [6:0]  broad_id_o;
  logic        busy_o;
  logic        timeout_err_o;

  mesi_isc_broad_snoop_cntl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .broad_fifo_empty_i(broad_fifo_empty_i), .broad_addr_i(broad_addr_i),
    .broad_type_i(broad_type_i), .broad_cpu_id_i(broad_cpu_id_i),
    .broad_id_i(broad_id_i), .broad_fifo_rd_o(broad_fifo_rd_o),
    .cbus_addr_o(cbus_addr_o), .cbus_cmd_array_o(cbus_cmd_array_o),
    .cbus_ack_array_i(cbus_ack_array_i), .broad_id_o(broad_id_o),
    .busy_o(busy_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [1:0]  cpu;
    logic [6:0]  id;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   rd_pulses = 0;

  // Model: set of CPUs still owed a snoop ack, plus an outstanding grant.
  logic [3:0]  m_need  = '0;
  bit          m_grant = 1'b0;
  logic [1:0]  m_orig  = '0;
  bit          m_wr    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [6:0]  m_id    = '0;

  always @(posedge clk) if (broad_fifo_rd_o === 1'b1) rd_pulses <= rd_pulses + 1;

  function automatic bit exp_busy();
    return (m_need != 4'd0) || m_grant;
  endfunction

  function automatic logic [2:0] exp_cmd(int i);
    if (m_need[i]) return m_wr ? 3'd1 : 3'd2;
    if (m_grant && m_orig == 2'(i)) return m_wr ? 3'd3 : 3'd4;
    return 3'd0;
  endfunction

  task automatic drive_head();
    broad_fifo_empty_i = (q.size() == 0);
    if (q.size() > 0) begin
      broad_addr_i = q[0].addr; broad_type_i = q[0].typ;
      broad_cpu_id_i = q[0].cpu; broad_id_i = q[0].id;
    end else begin
      broad_addr_i = '0; broad_type_i = '0; broad_cpu_id_i = '0; broad_id_i = '0;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] t, input logic [1:0] c, input logic [6:0] id);
    ent_t e;
    e.addr = a; e.typ = t; e.cpu = c; e.id = id;
    q.push_back(e);
    drive_head();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic tick();
    bit pop;
    pop = !rst && !exp_busy() && (q.size() > 0);
    if (rst) begin
      m_need = '0; m_grant = 1'b0; m_addr = '0; m_id = '0;
    end else if (m_need != 4'd0) begin
      m_need = m_need & ~cbus_ack_array_i;
      if (m_need == 4'd0) m_grant = 1'b1;
    end else if (m_grant) begin
      if (cbus_ack_array_i[m_orig]) m_grant = 1'b0;
    end else if (pop && q[0].typ != 2'd0) begin
      m_need = 4'hF & ~(4'b0001 << q[0].cpu);
      m_orig = q[0].cpu; m_wr = (q[0].typ == 2'd1);
      m_addr = q[0].addr; m_id = q[0].id;
    end
    @(posedge clk);
    if (pop) void'(q.pop_front());
    @(negedge clk);
    drive_head();
  endtask

  task automatic test_reset();
    rst = 1'b1; cbus_ack_array_i = '0; drive_head();
    tick(); tick(); #1;
    total++;
    if ({broad_fifo_rd_o, busy_o, timeout_err_o, cbus_cmd_array_o, cbus_addr_o, broad_id_o} !== '0) begin
      bad++;
      $display("FAIL reset_state rd=%b busy=%b err=%b cmd=%h addr=%h id=%h want all zero",
               broad_fifo_rd_o, busy_o, timeout_err_o, cbus_cmd_array_o, cbus_addr_o, broad_id_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_rd();
    int p0;
    logic [11:0] e;
    p0 = rd_pulses;
    push(32'h1000, 2'd2, 2'd2, 7'd5);
    cbus_ack_array_i = '0; #1;
    total++;
    if (broad_fifo_rd_o !== 1'b1) begin bad++; $display("FAIL rd_pop got=%b want=1", broad_fifo_rd_o); end
    tick(); #1;
    e = {3'd2, 3'd0, 3'd2, 3'd2};
    total++;
    if (cbus_cmd_array_o !== e || busy_o !== 1'b1 || cbus_addr_o !== 32'h1000 || broad_id_o !== 7'd5) begin
      bad++;
      $display("FAIL rd_snoop cmd=%h busy=%b addr=%h id=%0d want cmd=%h busy=1 addr=1000 id=5",
               cbus_cmd_array_o, busy_o, cbus_addr_o, broad_id_o, e);
    end
    tick();
    cbus_ack_array_i = 4'b1011; #1;
    total++;
    if (cbus_cmd_array_o !== e) begin bad++; $display("FAIL rd_snoop_hold cmd=%h want %h", cbus_cmd_array_o, e); end
    tick();
    cbus_ack_array_i = '0; #1;
    e = {3'd0, 3'd4, 3'd0, 3'd0};
    total++;
    if (cbus_cmd_array_o !== e || busy_o !== 1'b1) begin
      bad++; $display("FAIL rd_enable cmd=%h busy=%b want cmd=%h busy=1", cbus_cmd_array_o, busy_o, e);
    end
    tick();
    cbus_ack_array_i = 4'b0100; #1;
    total++;
    if (cbus_cmd_array_o !== e || busy_o !== 1'b1) begin
      bad++; $display("FAIL rd_enable_hold cmd=%h busy=%b want cmd=%h busy=1", cbus_cmd_array_o, busy_o, e);
    end
    tick();
    cbus_ack_array_i = '0; #1;
    total++;
    if (busy_o !== 1'b0 || cbus_cmd_array_o !== '0 || (rd_pulses - p0) != 1) begin
      bad++; $display("FAIL rd_done busy=%b cmd=%h pulses=%0d want busy=0 cmd=0 pulses=1",
                      busy_o, cbus_cmd_array_o, rd_pulses - p0);
    end
  endtask

  task automatic test_staggered_wr();
    logic [3:0]  ack_at [0:5];
    logic [11:0] want   [0:6];
    ack_at = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0001};
    want = '{{3'd1,3'd1,3'd1,3'd0}, {3'd1,3'd1,3'd0,3'd0}, {3'd1,3'd1,3'd0,3'd0},
             {3'd1,3'd0,3'd0,3'd0}, {3'd1,3'd0,3'd0,3'd0}, {3'd0,3'd0,3'd0,3'd3},
             {3'd0,3'd0,3'd0,3'd0}};
    push(32'hCAFE_0040, 2'd1, 2'd0, 7'd33);
    cbus_ack_array_i = '0;
    tick();
    // Cycle k is T+1+k; ENABLE must appear at T+6 (k=5).
    for (int k = 0; k < 7; k++) begin
      cbus_ack_array_i = (k < 5) ? ack_at[k] : ((k == 5) ? 4'b0001 : 4'b0000); #1;
      total++;
      if (cbus_cmd_array_o !== want[k]) begin
        bad++; $display("FAIL stagger_T+%0d cmd=%h want %h", k + 1, cbus_cmd_array_o, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_nop_then_rd();
    push(32'h0000_BEEF, 2'd0, 2'd1, 7'd9);
    push(32'h0000_2000, 2'd2, 2'd3, 7'd77);
    cbus_ack_array_i = '0; #1;
    total++;
    if (broad_fifo_rd_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL nop_pop rd=%b busy=%b want rd=1 busy=0", broad_fifo_rd_o, busy_o);
    end
    tick(); #1;
    total++;
    if (broad_fifo_rd_o !== 1'b1 || busy_o !== 1'b0 || cbus_cmd_array_o !== '0 || cbus_addr_o !== 32'hCAFE_0040) begin
      bad++; $display("FAIL nop_discard rd=%b busy=%b cmd=%h addr=%h want rd=1 busy=0 cmd=0 addr=cafe0040",
                      broad_fifo_rd_o, busy_o, cbus_cmd_array_o, cbus_addr_o);
    end
    tick();
    cbus_ack_array_i = 4'b0111; #1;
    total++;
    if (cbus_cmd_array_o !== {3'd0,3'd2,3'd2,3'd2} || cbus_addr_o !== 32'h2000 || broad_id_o !== 7'd77) begin
      bad++; $display("FAIL nop_next_rd cmd=%h addr=%h id=%0d want cmd=092 addr=2000 id=77",
                      cbus_cmd_array_o, cbus_addr_o, broad_id_o);
    end
    tick();
    cbus_ack_array_i = 4'b1000; #1;
    total++;
    if (cbus_cmd_array_o !== {3'd4,3'd0,3'd0,3'd0}) begin
      bad++; $display("FAIL nop_next_en cmd=%h want 800", cbus_cmd_array_o);
    end
    tick();
  endtask

  task automatic test_spurious_backlog();
    push(32'h0000_3000, 2'd2, 2'd1, 7'd1);
    push(32'h0000_4000, 2'd1, 2'd2, 7'd2);
    cbus_ack_array_i = '0;
    tick();
    cbus_ack_array_i = 4'b0011; #1;
    total++;
    if (broad_fifo_rd_o !== 1'b0) begin bad++; $display("FAIL backlog_pop1 rd=%b want 0", broad_fifo_rd_o); end
    tick();
    cbus_ack_array_i = 4'b1110; #1;
    total++;
    if (cbus_cmd_array_o !== {3'd2,3'd2,3'd0,3'd0} || broad_fifo_rd_o !== 1'b0) begin
      bad++; $display("FAIL spurious_orig cmd=%h rd=%b want cmd=480 rd=0", cbus_cmd_array_o, broad_fifo_rd_o);
    end
    tick();
    cbus_ack_array_i = '0; #1;
    total++;
    if (cbus_cmd_array_o !== {3'd0,3'd0,3'd4,3'd0} || broad_fifo_rd_o !== 1'b0) begin
      bad++; $display("FAIL backlog_en cmd=%h rd=%b want cmd=020 rd=0", cbus_cmd_array_o, broad_fifo_rd_o);
    end
    tick();
    cbus_ack_array_i = 4'b0010;
    tick(); #1;
    cbus_ack_array_i = '0;
    total++;
    if (busy_o !== 1'b0 || broad_fifo_rd_o !== 1'b1) begin
      bad++; $display("FAIL backlog_next busy=%b rd=%b want busy=0 rd=1", busy_o, broad_fifo_rd_o);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_busy() || q.size() > 0) && n < 200) begin
      rst = 1'b0; cbus_ack_array_i = 4'($urandom_range(0, 15));
      tick(); n++;
    end
    cbus_ack_array_i = '0;
    total++;
    if (exp_busy() || q.size() > 0) begin bad++; $display("FAIL drain_timeout busy=%b queued=%0d want idle", busy_o, q.size()); end
  endtask

  task automatic test_reset_mid_snoop();
    push(32'h0000_5000, 2'd2, 2'd0, 7'd3);
    cbus_ack_array_i = '0;
    tick(); tick();
    rst = 1'b1;
    tick(); #1;
    total++;
    if (cbus_cmd_array_o !== '0 || busy_o !== 1'b0 || broad_fifo_rd_o !== 1'b0 || cbus_addr_o !== '0) begin
      bad++; $display("FAIL reset_mid cmd=%h busy=%b rd=%b addr=%h want all zero",
                      cbus_cmd_array_o, busy_o, broad_fifo_rd_o, cbus_addr_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] e;
    for (int c = 0; c < 400; c++) begin
      if (q.size() < 4 && $urandom_range(0, 2) == 0)
        push($urandom, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 7'($urandom));
      rst = ($urandom_range(0, 149) == 0);
      cbus_ack_array_i = 4'($urandom_range(0, 15)); #1;
      for (int i = 0; i < 4; i++) e[i*3 +: 3] = exp_cmd(i);
      total++;
      if (cbus_cmd_array_o !== e || busy_o !== exp_busy() || cbus_addr_o !== m_addr || broad_id_o !== m_id ||
          broad_fifo_rd_o !== (!rst && !exp_busy() && q.size() > 0)) begin
        bad++; $display("FAIL rand_c%0d cmd=%h busy=%b addr=%h id=%h rd=%b want cmd=%h busy=%b addr=%h id=%h",
                        c, cbus_cmd_array_o, busy_o, cbus_addr_o, broad_id_o, broad_fifo_rd_o,
                        e, exp_busy(), m_addr, m_id);
      end
`ifndef MESI_ISC_BROAD_TIMEOUT_EN
      total++;
      if (timeout_err_o !== 1'b0) begin bad++; $display("FAIL rand_err_c%0d got=%b want 0", c, timeout_err_o); end
`endif
      tick();
    end
    rst = 1'b0;
  endtask

`ifdef MESI_ISC_BROAD_TIMEOUT_EN
  task automatic test_timeout();
    rst = 1'b1; cbus_ack_array_i = '0;
    tick();
    rst = 1'b0;
    push(32'h0000_6000, 2'd1, 2'd0, 7'd4);
    tick();
    cbus_ack_array_i = 4'b0110;
    tick();
    cbus_ack_array_i = '0;
    for (int k = 0; k < 8; k++) begin
      #1; total++;
      if (timeout_err_o !== 1'b0) begin bad++; $display("FAIL tmo_early_k%0d err=%b want 0", k, timeout_err_o); end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      #1; total++;
      if (timeout_err_o !== 1'b1 || cbus_cmd_array_o[11:9] !== 3'd1) begin
        bad++; $display("FAIL tmo_set_k%0d err=%b cmd3=%0d want err=1 cmd3=1", k, timeout_err_o, cbus_cmd_array_o[11:9]);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    total++;
    if (timeout_err_o !== 1'b0) begin bad++; $display("FAIL tmo_clear err=%b want 0", timeout_err_o); end
  endtask
`endif

  initial begin
    rst = 1'b1; cbus_ack_array_i = '0; drive_head();
    test_reset();
    test_single_rd();
    test_staggered_wr();
    test_nop_then_rd();
    test_spurious_backlog();
    drain();
    test_reset_mid_snoop();
    test_random();
    drain();
`ifdef MESI_ISC_BROAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
